lcd_nibble_controller: RTL and testbench
========================================

# lcd_nibble_controller

Hardware sequencer for the Spartan-3E character LCD (HD44780-compatible, 4-bit bus). It runs the power-on initialisation, then accepts one byte at a time from a host (MiniAlu or any other requester) over a valid/ready handshake. Each byte is split into two nibbles, with enable pulses and post-command waits generated in hardware, so the host no longer bit-bangs `oLCD` and `oEnable` in software. It sits between the datapath and the LCD pins.

## Interface
Parameters (defaults assume a 50 MHz clock):
- T_PWRUP, 750000: power-up wait before the first nibble (15 ms).
- T_INIT1, 205000: wait after the first 0x3 nibble (4.1 ms).
- T_INIT2, 5000: wait after the second 0x3, third 0x3 and the 0x2 nibble (100 µs).
- T_SETUP, 2: cycles during which RS and the data nibble are stable before enable rises.
- T_EN, 12: enable-high width in cycles (240 ns).
- T_NIB, 50: gap between the high and low nibble (1 µs).
- T_CMD, 2000: wait after a normal byte (40 µs).
- T_LONG, 82000: wait after a clear or home command (1.64 ms).
- CW, 20: delay counter width. Must satisfy 2^CW > every T_* value.

Ports:
- Clock, in, 1: single system clock, rising edge.
- Reset, in, 1: synchronous, active-high.
- iData, in, 8: byte to send.
- iRS, in, 1: 0 = command, 1 = data.
- iValid, in, 1: the host presents a byte.
- oReady, out, 1: the controller is idle and accepts a byte.
- oLCD, out, 4: LCD data bus, DB7..DB4.
- oEnable, out, 1: LCD E.
- oRegisterSelect, out, 1: LCD RS.
- oReadWrite, out, 1: LCD R/W. Tied to 0 (write only).
- oInitDone, out, 1: high once initialisation is complete. Stays high until Reset.

## Operation
- Reset values: all outputs 0, state S_PWRUP, delay counter loaded with T_PWRUP.
- A Reset asserted in any state, including mid-pulse, takes effect on the next edge and restarts the full init sequence.
- States:
  - S_PWRUP: wait T_PWRUP cycles, then go to S_INIT.
  - S_INIT: emit the init nibbles in order 0x3, 0x3, 0x3, 0x2, with RS=0. Each nibble uses the same pulse shape as S_HI. The waits after them are T_INIT1, T_INIT2, T_INIT2, T_INIT2.
  - Leaving S_INIT: go to S_CFG if the macro is defined, otherwise to S_IDLE.
  - S_IDLE: oReady=1 and oInitDone=1. On iValid&&oReady, latch iData and iRS and go to S_HI.
  - S_HI: drive the high nibble iData[7:4] and RS for T_SETUP cycles, then oEnable=1 for T_EN cycles, then oEnable=0 with data held for 1 cycle. Then go to S_GAP.
  - S_GAP: wait T_NIB cycles, then go to S_LO.
  - S_LO: same pulse shape as S_HI, driving iData[3:0]. Then go to S_WAIT.
  - S_WAIT: wait T_LONG if RS=0 and the byte is 0x01, 0x02 or 0x03; otherwise wait T_CMD. Then go to S_IDLE.
- oReady is high only in S_IDLE. Any iValid outside S_IDLE is ignored, with no queueing. The host holds iValid until it sees oReady.
- The latched byte and RS are stable from acceptance until the controller returns to S_IDLE, even if iData changes.
- oLCD and oRegisterSelect keep their last driven values while in wait states.

## Timing
- Handshake: acceptance at edge N requires oReady=1 and iValid=1. oReady drops at N+1.
- oLCD = high nibble from N+1. oEnable is high from N+1+T_SETUP for T_EN cycles.
- The low-nibble enable rises T_EN+1+T_NIB+T_SETUP cycles after the high-nibble enable rises.
- Byte throughput: one byte per 2·(T_SETUP+T_EN+1) + T_NIB + wait + 1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The delay counter loads T−1 and counts down to 0. A wait of T therefore takes exactly T cycles.

## Configuration
- LCD_AUTOCONFIG_EN defined:
  - After S_INIT, state S_CFG sends 0x28 (function set), 0x06 (entry mode), 0x0C (display on) and 0x01 (clear), all with RS=0.
  - Each byte uses the S_HI, S_GAP, S_LO and S_WAIT sequence. 0x01 gets T_LONG.
  - oInitDone and oReady rise only after the clear wait ends.
- LCD_AUTOCONFIG_EN undefined:
  - S_CFG is absent. oInitDone rises at entry to S_IDLE, right after the 0x2 nibble wait.
  - The host issues the configuration bytes itself.

## Structure
- Package lcd_pkg holds:
  - the state encoding;
  - the default timing constants;
  - init nibble constants (0x3, 0x2);
  - autoconfig command constants (0x28, 0x06, 0x0C, 0x01);
  - the long-command opcode list.
- Sub-module lcd_delay_counter: a CW-bit loadable down-counter with iLoad, iValue and oDone. It is instantiated once and shared by every wait and pulse phase.

## Test plan
Bench parameters: T_PWRUP=20, T_INIT1=10, T_INIT2=5, T_SETUP=2, T_EN=3, T_NIB=4, T_CMD=6, T_LONG=15. LCD_AUTOCONFIG_EN undefined unless stated.
- Reset release → four enable pulses with oLCD 0x3, 0x3, 0x3, 0x2. The first pulse rises 20+2 cycles after reset. oInitDone=1 after the last 5-cycle wait.
- Data 0x41 with RS=1 → pulses on oLCD 0x4 then 0x1, each with RS=1 and 3 cycles wide. The controller returns to oReady 6 cycles after the low pulse.
- Command 0x01 with RS=0 → post-wait of 15 cycles. Command 0x01 with RS=1 → wait of 6 cycles.
- Second iValid while busy, with iData=0x55 changed mid-transfer → the original byte completes unaltered and the second byte is accepted only when oReady=1.
- Reset asserted during an enable-high phase → oEnable=0 and all outputs 0 on the next cycle, and the power-up sequence restarts.
- LCD_AUTOCONFIG_EN defined → bytes 0x28, 0x06, 0x0C, 0x01 appear as nibble pairs after init. oInitDone rises only after the 15-cycle clear wait.

Source files
------------

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 4-bit LCD sequencer:
//   - controller state and pulse sub-phase encodings
//   - default timing constants (cycles at 50 MHz)
//   - init nibbles, autoconfig command bytes and long-running opcodes
//   - helpers to pick the autoconfig byte and classify long commands
// Optional feature macro used by the controller: LCD_AUTOCONFIG_EN
// -----------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT,
      S_CFG,
      S_IDLE,
      S_HI,
      S_GAP,
      S_LO,
      S_WAIT
   } state_t;

   // Sub-phases of one nibble transfer; PH_POST is the wait after an init nibble.
   typedef enum logic [1:0] {
      PH_SETUP,
      PH_EN,
      PH_HOLD,
      PH_POST
   } phase_t;

   localparam int DEF_T_PWRUP = 750000;
   localparam int DEF_T_INIT1 = 205000;
   localparam int DEF_T_INIT2 = 5000;
   localparam int DEF_T_SETUP = 2;
   localparam int DEF_T_EN    = 12;
   localparam int DEF_T_NIB   = 50;
   localparam int DEF_T_CMD   = 2000;
   localparam int DEF_T_LONG  = 82000;
   localparam int DEF_CW      = 20;

   localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
   localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

   localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
   localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT   = 8'h03;

   function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_ENTRY_MODE;
         2'd2:    return CMD_DISPLAY_ON;
         default: return CMD_CLEAR;
      endcase
   endfunction

   // Clear and home take ~1.64 ms on the panel; everything else ~40 us.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME) || (b == CMD_HOME_ALT));
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// -----------------------------------------------------------------------------
// lcd_delay_counter
// Loadable down-counter shared by every wait and pulse phase of the LCD
// sequencer. Loading T-1 makes oDone rise after exactly T cycles.
// Ports:
//   Clock  - system clock, rising edge
//   iLoad  - load iValue this edge (has priority over counting)
//   iValue - value to load (phase length minus one)
//   oDone  - count has reached zero
// -----------------------------------------------------------------------------
module lcd_delay_counter #(
   parameter int CW = 20
) (
   input  logic          Clock,
   input  logic          iLoad,
   input  logic [CW-1:0] iValue,
   output logic          oDone
);

   logic [CW-1:0] r_count;

   always_ff @(posedge Clock) begin
      if (iLoad)
         r_count <= iValue;
      else if (r_count != '0)
         r_count <= r_count - CW'(1);
   end

   assign oDone = (r_count == '0);

endmodule

// File: rtl/lcd_nibble_controller.sv
// -----------------------------------------------------------------------------
// lcd_nibble_controller
// Hardware sequencer for an HD44780-compatible LCD on a 4-bit bus. Runs the
// power-on init (0x3,0x3,0x3,0x2), then sends host bytes as two nibbles with
// generated enable pulses and post-command waits.
// Optional feature: define LCD_AUTOCONFIG_EN to send 0x28,0x06,0x0C,0x01
// automatically after init, before the host is given oReady.
// Ports:
//   Clock           - system clock, rising edge
//   Reset           - synchronous, active-high; restarts the full init
//   iData[7:0]      - byte to send
//   iRS             - 0 = command, 1 = data
//   iValid          - host presents a byte
//   oReady          - idle, byte accepted on iValid
//   oLCD[3:0]       - LCD DB7..DB4
//   oEnable         - LCD E
//   oRegisterSelect - LCD RS
//   oReadWrite      - LCD R/W, always 0
//   oInitDone       - initialisation complete (sticky until Reset)
// -----------------------------------------------------------------------------
module lcd_nibble_controller
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = DEF_T_PWRUP,
   parameter int T_INIT1 = DEF_T_INIT1,
   parameter int T_INIT2 = DEF_T_INIT2,
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_EN    = DEF_T_EN,
   parameter int T_NIB   = DEF_T_NIB,
   parameter int T_CMD   = DEF_T_CMD,
   parameter int T_LONG  = DEF_T_LONG,
   parameter int CW      = DEF_CW
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iRS,
   input  logic       iValid,
   output logic       oReady,
   output logic [3:0] oLCD,
   output logic       oEnable,
   output logic       oRegisterSelect,
   output logic       oReadWrite,
   output logic       oInitDone
);

   // Counter load values: a phase of T cycles loads T-1.
   localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 1);
   localparam logic [CW-1:0] L_INIT1 = CW'(T_INIT1 - 1);
   localparam logic [CW-1:0] L_INIT2 = CW'(T_INIT2 - 1);
   localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
   localparam logic [CW-1:0] L_NIB   = CW'(T_NIB - 1);
   localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
   localparam logic [CW-1:0] L_LONG  = CW'(T_LONG - 1);

   state_t        r_state, w_state;
   phase_t        r_ph, w_ph;
   logic [1:0]    r_idx, w_idx;
   logic [7:0]    r_byte, w_byte;
   logic          r_rs, w_rs;
   logic          r_cfg, w_cfg;
   logic [3:0]    r_lcd, w_lcd;
   logic          r_en, w_en;
   logic          r_rso, w_rso;
   logic          r_ready, w_ready;
   logic          r_initdone, w_initdone;
   logic          w_load;
   logic [CW-1:0] w_value;
   logic          w_cnt_load;
   logic [CW-1:0] w_cnt_value;
   logic          w_done;

`ifdef LCD_AUTOCONFIG_EN
   logic [7:0]    w_cfg_byte;
   assign w_cfg_byte = cfg_byte(r_idx);
`endif

   // Reset reloads the power-up wait so the sequence restarts from scratch.
   assign w_cnt_load  = Reset | w_load;
   assign w_cnt_value = Reset ? L_PWRUP : w_value;

   lcd_delay_counter #(.CW(CW)) u_delay (
      .Clock  (Clock),
      .iLoad  (w_cnt_load),
      .iValue (w_cnt_value),
      .oDone  (w_done)
   );

   always_comb begin
      w_state    = r_state;
      w_ph       = r_ph;
      w_idx      = r_idx;
      w_byte     = r_byte;
      w_rs       = r_rs;
      w_cfg      = r_cfg;
      w_lcd      = r_lcd;
      w_en       = r_en;
      w_rso      = r_rso;
      w_ready    = 1'b0;
      w_initdone = r_initdone;
      w_load     = 1'b0;
      w_value    = '0;

      case (r_state)
         S_PWRUP: begin
            if (w_done) begin
               w_state = S_INIT;
               w_ph    = PH_SETUP;
               w_idx   = 2'd0;
               w_lcd   = INIT_NIB_8BIT;
               w_rso   = 1'b0;
               w_load  = 1'b1;
               w_value = L_SETUP;
            end
         end

         // Init nibbles and both halves of a byte share one pulse shape:
         // setup, enable high, one hold cycle with enable low.
         S_INIT, S_HI, S_LO: begin
            case (r_ph)
               PH_SETUP: begin
                  if (w_done) begin
                     w_ph    = PH_EN;
                     w_en    = 1'b1;
                     w_load  = 1'b1;
                     w_value = L_EN;
                  end
               end
               PH_EN: begin
                  if (w_done) begin
                     w_ph    = PH_HOLD;
                     w_en    = 1'b0;
                     w_load  = 1'b1;
                     w_value = '0;
                  end
               end
               PH_HOLD: begin
                  if (w_done) begin
                     w_load = 1'b1;
                     if (r_state == S_HI) begin
                        w_state = S_GAP;
                        w_value = L_NIB;
                     end else if (r_state == S_LO) begin
                        w_state = S_WAIT;
                        w_value = is_long_cmd(r_rs, r_byte) ? L_LONG : L_CMD;
                     end else begin
                        w_ph    = PH_POST;
                        w_value = (r_idx == 2'd0) ? L_INIT1 : L_INIT2;
                     end
                  end
               end
               default: begin
                  if (w_done && (r_state == S_INIT)) begin
                     if (r_idx == 2'd3) begin
`ifdef LCD_AUTOCONFIG_EN
                        w_state = S_CFG;
                        w_idx   = 2'd0;
`else
                        w_state    = S_IDLE;
                        w_ready    = 1'b1;
                        w_initdone = 1'b1;
`endif
                     end else begin
                        // Nibble index 3 (the fourth) switches the panel to 4-bit mode.
                        w_idx   = r_idx + 2'd1;
                        w_ph    = PH_SETUP;
                        w_lcd   = (r_idx == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
                        w_load  = 1'b1;
                        w_value = L_SETUP;
                     end
                  end
               end
            endcase
         end

`ifdef LCD_AUTOCONFIG_EN
         S_CFG: begin
            w_byte  = w_cfg_byte;
            w_rs    = 1'b0;
            w_cfg   = 1'b1;
            w_state = S_HI;
            w_ph    = PH_SETUP;
            w_lcd   = w_cfg_byte[7:4];
            w_rso   = 1'b0;
            w_load  = 1'b1;
            w_value = L_SETUP;
         end
`endif

         S_IDLE: begin
            w_ready = 1'b1;
            if (iValid && r_ready) begin
               w_byte  = iData;
               w_rs    = iRS;
               w_state = S_HI;
               w_ph    = PH_SETUP;
               w_lcd   = iData[7:4];
               w_rso   = iRS;
               w_ready = 1'b0;
               w_load  = 1'b1;
               w_value = L_SETUP;
            end
         end

         S_GAP: begin
            if (w_done) begin
               w_state = S_LO;
               w_ph    = PH_SETUP;
               w_lcd   = r_byte[3:0];
               w_load  = 1'b1;
               w_value = L_SETUP;
            end
         end

         S_WAIT: begin
            if (w_done) begin
               if (r_cfg && (r_idx != 2'd3)) begin
                  w_idx   = r_idx + 2'd1;
                  w_state = S_CFG;
               end else begin
                  w_cfg      = 1'b0;
                  w_state    = S_IDLE;
                  w_ready    = 1'b1;
                  w_initdone = 1'b1;
               end
            end
         end

         default: begin
            w_state = S_PWRUP;
            w_load  = 1'b1;
            w_value = L_PWRUP;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_PWRUP;
         r_ph       <= PH_SETUP;
         r_idx      <= 2'd0;
         r_cfg      <= 1'b0;
         r_lcd      <= 4'h0;
         r_en       <= 1'b0;
         r_rso      <= 1'b0;
         r_ready    <= 1'b0;
         r_initdone <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_ph       <= w_ph;
         r_idx      <= w_idx;
         r_cfg      <= w_cfg;
         r_lcd      <= w_lcd;
         r_en       <= w_en;
         r_rso      <= w_rso;
         r_ready    <= w_ready;
         r_initdone <= w_initdone;
      end
   end

   // Latched byte is pure data; it is only consumed after a fresh load.
   always_ff @(posedge Clock) begin
      r_byte <= w_byte;
      r_rs   <= w_rs;
   end

   assign oReady          = r_ready;
   assign oLCD            = r_lcd;
   assign oEnable         = r_en;
   assign oRegisterSelect = r_rso;
   assign oReadWrite      = 1'b0;
   assign oInitDone       = r_initdone;

endmodule

// File: tb/tb_lcd_nibble_controller.sv
`timescale 1ns/1ps
module tb_lcd_nibble_controller;

   localparam int P_PWRUP = 20;
   localparam int P_INIT1 = 10;
   localparam int P_INIT2 = 5;
   localparam int P_SETUP = 2;
   localparam int P_EN    = 3;
   localparam int P_NIB   = 4;
   localparam int P_CMD   = 6;
   localparam int P_LONG  = 15;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] iData;
   logic       iRS;
   logic       iValid;
   logic       oReady;
   logic [3:0] oLCD;
   logic       oEnable;
   logic       oRegisterSelect;
   logic       oReadWrite;
   logic       oInitDone;

   lcd_nibble_controller #(
      .T_PWRUP (P_PWRUP),
      .T_INIT1 (P_INIT1),
      .T_INIT2 (P_INIT2),
      .T_SETUP (P_SETUP),
      .T_EN    (P_EN),
      .T_NIB   (P_NIB),
      .T_CMD   (P_CMD),
      .T_LONG  (P_LONG),
      .CW      (20)
   ) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .iData           (iData),
      .iRS             (iRS),
      .iValid          (iValid),
      .oReady          (oReady),
      .oLCD            (oLCD),
      .oEnable         (oEnable),
      .oRegisterSelect (oRegisterSelect),
      .oReadWrite      (oReadWrite),
      .oInitDone       (oInitDone)
   );

   always #5 Clock = ~Clock;

   // Number of rising edges so far; read on the falling edge.
   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   // Enable-pulse recorder: rise cycle, nibble, RS and width of every pulse.
   int         p_start [128];
   logic [3:0] p_nib   [128];
   logic       p_rs    [128];
   int         p_w     [128];
   int         n_p = 0;
   logic       prev_en = 1'b0;

   always @(negedge Clock) begin
      if (oEnable && !prev_en && (n_p < 128)) begin
         p_start[n_p] <= cyc;
         p_nib[n_p]   <= oLCD;
         p_rs[n_p]    <= oRegisterSelect;
         p_w[n_p]     <= 0;
         n_p          <= n_p + 1;
      end
      if (!oEnable && prev_en && (n_p > 0))
         p_w[n_p-1] <= cyc - p_start[n_p-1];
      prev_en <= oEnable;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // which: 0 = oReady, 1 = oInitDone, other = oEnable. Returns the cycle seen.
   task automatic wait_sig(input string tag, input int which, input int lim, output int at);
      int   t;
      logic s;
      t  = 0;
      s  = 1'b0;
      at = -1;
      while (!s && (t < lim)) begin
         @(negedge Clock);
         t++;
         case (which)
            0:       s = oReady;
            1:       s = oInitDone;
            default: s = oEnable;
         endcase
      end
      if (s) at = cyc;
      else   check_val({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_pulse(input string tag, input int idx, input int exp_start,
                              input int exp_nib, input int exp_rs);
      if (idx >= n_p) begin
         check_val({tag, "_present"}, n_p, idx + 1);
         return;
      end
      check_val({tag, "_start"}, p_start[idx], exp_start);
      check_val({tag, "_nib"},   p_nib[idx],   exp_nib);
      check_val({tag, "_rs"},    p_rs[idx],    exp_rs);
      check_val({tag, "_width"}, p_w[idx],     P_EN);
   endtask

   // Called on a falling edge. n_acc = edge that accepts the byte.
   task automatic send_byte(input logic [7:0] d, input logic rs, output int n_acc, output int base);
      int at;
      if (!oReady) wait_sig("pre_send", 0, 1000, at);
      base   = n_p;
      n_acc  = cyc + 1;
      iData  = d;
      iRS    = rs;
      iValid = 1'b1;
      @(negedge Clock);
      iValid = 1'b0;
      check_val("ready_drop", oReady, 0);
   endtask

   // Accept at n: hi rises n+2, falls n+5, gap to n+10, lo rises n+12,
   // falls n+15, hold to n+16, then wait; ready at n+22 (T_CMD) or n+31 (T_LONG).
   task automatic check_byte(input string tag, input logic [7:0] d, input logic rs, input int exp_rdy);
      int n, base, rdy;
      send_byte(d, rs, n, base);
      wait_sig(tag, 0, 1000, rdy);
      check_pulse({tag, "_hi"}, base,     n + 2,  int'(d[7:4]), int'(rs));
      check_pulse({tag, "_lo"}, base + 1, n + 12, int'(d[3:0]), int'(rs));
      check_val({tag, "_npulse"}, n_p - base, 2);
      check_val({tag, "_ready_at"}, rdy - n, exp_rdy);
   endtask

   // r0 = last edge with Reset high. Init rises at r0+22, then +16 (after the
   // 10-cycle wait), +11, +11 (5-cycle waits); last falls r0+63, done r0+69.
   task automatic check_init(input int r0, input int base);
      int done;
      wait_sig("init_done", 1, 2000, done);
      check_pulse("init0", base,     r0 + 22, 3, 0);
      check_pulse("init1", base + 1, r0 + 38, 3, 0);
      check_pulse("init2", base + 2, r0 + 49, 3, 0);
      check_pulse("init3", base + 3, r0 + 60, 2, 0);
`ifdef LCD_AUTOCONFIG_EN
      // S_CFG at r0+69, first hi at r0+72; bytes every 23 cycles; clear lo
      // falls r0+154, 1 hold + 15 wait -> done at r0+170.
      check_pulse("cfg28_hi", base + 4,  r0 + 72,  4'h2, 0);
      check_pulse("cfg28_lo", base + 5,  r0 + 82,  4'h8, 0);
      check_pulse("cfg06_hi", base + 6,  r0 + 95,  4'h0, 0);
      check_pulse("cfg06_lo", base + 7,  r0 + 105, 4'h6, 0);
      check_pulse("cfg0C_hi", base + 8,  r0 + 118, 4'h0, 0);
      check_pulse("cfg0C_lo", base + 9,  r0 + 128, 4'hC, 0);
      check_pulse("cfg01_hi", base + 10, r0 + 141, 4'h0, 0);
      check_pulse("cfg01_lo", base + 11, r0 + 151, 4'h1, 0);
      check_val("init_done_at", done - r0, 170);
      check_val("init_npulse", n_p - base, 12);
`else
      check_val("init_done_at", done - r0, 69);
      check_val("init_npulse", n_p - base, 4);
`endif
      check_val("ready_at_done", oReady, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_lcd"},   oLCD, 0);
      check_val({tag, "_en"},    oEnable, 0);
      check_val({tag, "_rs"},    oRegisterSelect, 0);
      check_val({tag, "_rw"},    oReadWrite, 0);
      check_val({tag, "_ready"}, oReady, 0);
      check_val({tag, "_done"},  oInitDone, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, base, at, n, b2;
      Reset  = 1'b1;
      iValid = 1'b0;
      iData  = 8'h00;
      iRS    = 1'b0;
      repeat (3) @(negedge Clock);
      check_all_zero("rst");

      base  = n_p;
      Reset = 1'b0;
      r0    = cyc;
      check_init(r0, base);

      check_byte("d41", 8'h41, 1'b1, 22);
      check_byte("c01", 8'h01, 1'b0, 31);
      check_byte("d01", 8'h01, 1'b1, 22);
      check_byte("c02", 8'h02, 1'b0, 31);
      check_byte("c04", 8'h04, 1'b0, 22);

      // Host raises a new byte while busy and changes iData mid-transfer.
      send_byte(8'hA7, 1'b1, n, base);
      repeat (3) @(negedge Clock);
      iData  = 8'h55;
      iRS    = 1'b0;
      iValid = 1'b1;
      wait_sig("ovl_ready", 0, 1000, at);
      @(negedge Clock);
      iValid = 1'b0;
      check_pulse("ovl_hi", base,     n + 2,  4'hA, 1);
      check_pulse("ovl_lo", base + 1, n + 12, 4'h7, 1);
      check_val("ovl_ready_at", at - n, 22);
      wait_sig("ovl2_ready", 0, 1000, b2);
      check_pulse("ovl2_hi", base + 2, at + 3,  4'h5, 0);
      check_pulse("ovl2_lo", base + 3, at + 13, 4'h5, 0);
      check_val("ovl_npulse", n_p - base, 4);

      // Reset while enable is high.
      send_byte(8'h33, 1'b1, n, base);
      wait_sig("mid_en", 2, 100, at);
      Reset = 1'b1;
      @(negedge Clock);
      check_all_zero("mid_rst");
      base  = n_p;
      Reset = 1'b0;
      r0    = cyc;
      check_init(r0, base);
      check_byte("post", 8'h5A, 1'b1, 22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
